// File: rtl/usart_tx_if.sv
// usart_tx_if: byte-write / status bundle between usart_ctrl (master) and
// usart_tx (slave). The serial pin is not part of this bundle.
`timescale 1ns/1ps

interface usart_tx_if;
  logic       write;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;

  modport master (
    output write, data_in,
    input  full, empty, busy, overflow
  );

  modport slave (
    input  write, data_in,
    output full, empty, busy, overflow
  );
endinterface

// File: rtl/usart_tx.sv
// usart_tx: buffered 8-bit asynchronous serial transmitter.
// Bytes written through the bus interface are queued in a small FIFO and sent
// LSB-first as 8N1 frames at CLOCK_FREQ/BAUD clocks per bit.
// Optional feature macro: USART_TX_PARITY_EN (adds an even-parity bit, 8E1).
`timescale 1ns/1ps

module usart_tx #(
  parameter int CLOCK_FREQ = 16_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  usart_tx_if.slave   bus,
  output logic        tx_pin
);

  localparam int DIVISOR = CLOCK_FREQ / BAUD;
  localparam int DIV_W   = $clog2(DIVISOR);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef USART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // FIFO storage and bookkeeping
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;

  // Serializer state
  logic [2:0]       state_reg;
  logic [DIV_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             tx_reg;
`ifdef USART_TX_PARITY_EN
  logic             parity_reg;
`endif

  logic       fifo_full;
  logic       fifo_empty;
  logic       baud_tick;
  logic       pop;
  logic       push;
  logic [7:0] head_byte;

  assign fifo_full  = (count_reg == COUNT_FULL);
  assign fifo_empty = (count_reg == '0);
  assign baud_tick  = (baud_cnt_reg == '0);
  assign head_byte  = fifo_mem[rd_ptr_reg];

  // The serializer takes a byte either from IDLE or at the last clock of STOP,
  // which is what lets frames run back-to-back with no idle gap.
  assign pop  = !fifo_empty &&
                ((state_reg == S_IDLE) || ((state_reg == S_STOP) && baud_tick));
  // A pop in the same cycle frees a slot, so a write into a full FIFO is kept.
  assign push = bus.write && (!fifo_full || pop);

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.busy     = (state_reg != S_IDLE);
  assign bus.overflow = overflow_reg;
  assign tx_pin       = tx_reg;

  // FIFO data array: no reset, contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= bus.data_in;
    end
  end

  // FIFO pointers, occupancy count and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (bus.write && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Frame serializer: each line bit is held for DIVISOR clocks from a register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
`ifdef USART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            shift_reg    <= head_byte;
            state_reg    <= S_START;
            tx_reg       <= 1'b0;
            baud_cnt_reg <= DIV_LOAD;
`ifdef USART_TX_PARITY_EN
            parity_reg   <= ^head_byte;
`endif
          end
        end

        S_START: begin
          if (baud_tick) begin
            state_reg    <= S_DATA;
            tx_reg       <= shift_reg[0];
            shift_reg    <= shift_reg >> 1;
            bit_idx_reg  <= '0;
            baud_cnt_reg <= DIV_LOAD;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end

        S_DATA: begin
          if (baud_tick) begin
            baud_cnt_reg <= DIV_LOAD;
            bit_idx_reg  <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == 3'd7) begin
`ifdef USART_TX_PARITY_EN
              state_reg <= S_PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= S_STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              tx_reg    <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end

`ifdef USART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_tick) begin
            state_reg    <= S_STOP;
            tx_reg       <= 1'b1;
            baud_cnt_reg <= DIV_LOAD;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (baud_tick) begin
            if (pop) begin
              shift_reg    <= head_byte;
              state_reg    <= S_START;
              tx_reg       <= 1'b0;
              baud_cnt_reg <= DIV_LOAD;
`ifdef USART_TX_PARITY_EN
              parity_reg   <= ^head_byte;
`endif
            end else begin
              state_reg <= S_IDLE;
              tx_reg    <= 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usart_tx.sv
// tb_usart_tx: directed bench for usart_tx with DIVISOR=4, FIFO_DEPTH=4.
// Line samples are taken on the falling edge, one per clock.
`timescale 1ns/1ps

module tb_usart_tx;

  localparam int DIV = 4;
`ifdef USART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int FCLK = FBITS * DIV;

  logic clk;
  logic reset;
  logic tx_pin;
  int   checks;
  int   errors;
  logic samp [0:255];

  usart_tx_if bus_if ();

  usart_tx #(
    .CLOCK_FREQ (16),
    .BAUD       (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .tx_pin (tx_pin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected line sequence for one frame, index 0 = start bit
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef USART_TX_PARITY_EN
    f[9]  = ^b;
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
`endif
    return f;
  endfunction

  // Record tx_pin on the next n falling edges
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      samp[i] = tx_pin;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_if.write = 1'b0;
    bus_if.data_in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx_pin); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus_if.empty); end
    checks++; if (bus_if.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus_if.full); end
    checks++; if (bus_if.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus_if.overflow); end
    $display("reset: tx=%b busy=%b empty=%b full=%b overflow=%b",
             tx_pin, bus_if.busy, bus_if.empty, bus_if.full, bus_if.overflow);
  endtask

  task automatic test_single;
    logic [10:0] exp;
    logic        bad;
    logic        got;
    @(negedge clk);
    bus_if.write = 1'b1;
    bus_if.data_in = 8'h55;
    @(negedge clk);
    bus_if.write = 1'b0;
    bus_if.data_in = 8'h00;
    // Byte stored at this edge, pop happens on the next one
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL single_latency_busy: got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.empty !== 1'b0) begin errors++; $display("FAIL single_latency_empty: got %b expected 0", bus_if.empty); end
    capture(FCLK);
    exp = frame_bits(8'h55);
    for (int j = 0; j < FBITS; j++) begin
      bad = 1'b0;
      got = samp[j*DIV];
      for (int k = 0; k < DIV; k++) begin
        if (samp[j*DIV+k] !== exp[j]) begin bad = 1'b1; got = samp[j*DIV+k]; end
      end
      checks++;
      if (bad) begin errors++; $display("FAIL single_frame bit %0d: got %b expected %b", j, got, exp[j]); end
    end
    @(negedge clk);
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL single_end_busy: got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.empty !== 1'b1) begin errors++; $display("FAIL single_end_empty: got %b expected 1", bus_if.empty); end
    checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL single_end_tx: got %b expected 1", tx_pin); end
    $display("single: byte 55 sent, %0d clocks observed", FCLK);
  endtask

  task automatic test_back_to_back;
    logic [7:0]  bytes [0:1];
    logic [10:0] exp;
    logic        bad;
    logic        got;
    bytes[0] = 8'hA1;
    bytes[1] = 8'h02;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 2; i++) begin
          bus_if.write = 1'b1;
          bus_if.data_in = bytes[i];
          @(negedge clk);
        end
        bus_if.write = 1'b0;
        bus_if.data_in = 8'h00;
      end
      begin
        @(negedge clk);
        capture(2 * FCLK);
      end
    join
    for (int f = 0; f < 2; f++) begin
      exp = frame_bits(bytes[f]);
      for (int j = 0; j < FBITS; j++) begin
        bad = 1'b0;
        got = samp[f*FCLK + j*DIV];
        for (int k = 0; k < DIV; k++) begin
          if (samp[f*FCLK + j*DIV + k] !== exp[j]) begin bad = 1'b1; got = samp[f*FCLK + j*DIV + k]; end
        end
        checks++;
        if (bad) begin errors++; $display("FAIL b2b_frame%0d bit %0d: got %b expected %b", f, j, got, exp[j]); end
      end
    end
    @(negedge clk);
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy: got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.empty !== 1'b1) begin errors++; $display("FAIL b2b_end_empty: got %b expected 1", bus_if.empty); end
    $display("back_to_back: bytes a1 02 sent in %0d clocks", 2 * FCLK);
  endtask

  task automatic test_overflow;
    logic [7:0]  bytes [0:5];
    logic [10:0] exp;
    logic        bad;
    logic        got;
    for (int i = 0; i < 6; i++) bytes[i] = 8'h10 + 8'(i);
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          bus_if.write = 1'b1;
          bus_if.data_in = bytes[i];
          @(negedge clk);
          if (i == 4) begin
            checks++; if (bus_if.overflow !== 1'b0) begin errors++; $display("FAIL ovf_before_drop: got %b expected 0", bus_if.overflow); end
          end
        end
        bus_if.write = 1'b0;
        bus_if.data_in = 8'h00;
        checks++; if (bus_if.full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", bus_if.full); end
        checks++; if (bus_if.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", bus_if.overflow); end
      end
      begin
        @(negedge clk);
        capture(5 * FCLK);
      end
    join
    for (int f = 0; f < 5; f++) begin
      exp = frame_bits(bytes[f]);
      for (int j = 0; j < FBITS; j++) begin
        bad = 1'b0;
        got = samp[f*FCLK + j*DIV];
        for (int k = 0; k < DIV; k++) begin
          if (samp[f*FCLK + j*DIV + k] !== exp[j]) begin bad = 1'b1; got = samp[f*FCLK + j*DIV + k]; end
        end
        checks++;
        if (bad) begin errors++; $display("FAIL ovf_frame%0d bit %0d: got %b expected %b", f, j, got, exp[j]); end
      end
    end
    @(negedge clk);
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL ovf_end_busy: got %b expected 0 (dropped byte sent?)", bus_if.busy); end
    checks++; if (bus_if.empty !== 1'b1) begin errors++; $display("FAIL ovf_end_empty: got %b expected 1", bus_if.empty); end
    checks++; if (bus_if.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus_if.overflow); end
    $display("overflow: bytes 10..14 sent, 15 dropped, overflow=%b", bus_if.overflow);
  endtask

  task automatic test_reset_midframe;
    int lows;
    int busies;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus_if.overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf_clear: got %b expected 0", bus_if.overflow); end
    bus_if.write = 1'b1;
    bus_if.data_in = 8'hFF;
    @(negedge clk);
    bus_if.data_in = 8'h33;
    @(negedge clk);
    bus_if.data_in = 8'h44;
    @(negedge clk);
    bus_if.write = 1'b0;
    bus_if.data_in = 8'h00;
    // Start bit appeared one clock ago; advance into data bit 3
    repeat (16) @(negedge clk);
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b expected 1", bus_if.busy); end
    checks++; if (bus_if.empty !== 1'b0) begin errors++; $display("FAIL midrst_pre_empty: got %b expected 0", bus_if.empty); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b expected 1", tx_pin); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", bus_if.empty); end
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    busies = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_pin !== 1'b1) lows++;
      if (bus_if.busy !== 1'b0) busies++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL midrst_quiet_line: got %0d non-idle clocks expected 0", lows); end
    checks++; if (busies != 0) begin errors++; $display("FAIL midrst_quiet_busy: got %0d busy clocks expected 0", busies); end
    $display("reset_midframe: frame aborted, queue flushed");
  endtask

`ifdef USART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0]  bytes [0:1];
    logic [0:10] exp [0:1];
    logic        bad;
    logic        got;
    bytes[0] = 8'h07;
    bytes[1] = 8'h03;
    exp[0]   = 11'b01110000011;
    exp[1]   = 11'b01100000001;
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      bus_if.write = 1'b1;
      bus_if.data_in = bytes[f];
      @(negedge clk);
      bus_if.write = 1'b0;
      bus_if.data_in = 8'h00;
      capture(11 * DIV);
      for (int j = 0; j < 11; j++) begin
        bad = 1'b0;
        got = samp[j*DIV];
        for (int k = 0; k < DIV; k++) begin
          if (samp[j*DIV+k] !== exp[f][j]) begin bad = 1'b1; got = samp[j*DIV+k]; end
        end
        checks++;
        if (bad) begin errors++; $display("FAIL parity_%h bit %0d: got %b expected %b", bytes[f], j, got, exp[f][j]); end
      end
      @(negedge clk);
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL parity_%h_end_busy: got %b expected 0", bytes[f], bus_if.busy); end
      $display("parity: byte %h sent as 11-bit frame", bytes[f]);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus_if.write = 1'b0;
    bus_if.data_in = 8'h00;
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_reset_midframe;
`ifdef USART_TX_PARITY_EN
    test_parity;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
